dsp_post_adder: RTL and testbench
=================================

DSP_POST_ADDER -- requirements
Module: dsp_post_adder

Interface
REQ-001 Parameter PREG, default 1, meaning: 1 = P output registered, 0 = P combinational.
REQ-002 Parameter CARRYOUTREG, default 1, meaning: 1 = carryout registered, 0 = carryout combinational.
REQ-003 Port clk, input, 1, meaning: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, meaning: synchronous, active-high reset for P, carryout and ovf.
REQ-005 Port cep, input, 1, meaning: clock enable for the P, carryout and ovf registers.
REQ-006 Port opmode, input, 8, meaning: bit7 = subtract, bits[3:2] = Z select, bits[1:0] = X select; bits[6:4] are ignored.
REQ-007 Port m, input, 36, meaning: multiplier product, sign-extended to 48 bits at the X mux.
REQ-008 Port dab, input, 48, meaning: concatenated D[11:0],A[17:0],B[17:0] operand.
REQ-009 Port pcin, input, 48, meaning: cascade input from the previous slice.
REQ-010 Port c, input, 48, meaning: C operand, already registered upstream.
REQ-011 Port carryin, input, 1, meaning: carry-in output of the upstream 1-bit carry-in register/bypass stage.
REQ-012 Port p, output, 48, meaning: post-adder result.
REQ-013 Port pcout, output, 48, meaning: cascade output, always equal to p.
REQ-014 Port carryout, output, 1, meaning: bit 48 of the post-adder sum.
REQ-015 Port carryoutf, output, 1, meaning: fabric copy of carryout, always equal to carryout.
REQ-016 Port ovf, output, 1, meaning: sticky signed-overflow flag.

Function
REQ-017 The X mux SHALL select by opmode[1:0]: 0 = zero, 1 = sign-extended m, 2 = P feedback, 3 = dab.
REQ-018 The Z mux SHALL select by opmode[3:2]: 0 = zero, 1 = pcin, 2 = P feedback, 3 = c.
REQ-019 The sum SHALL be computed in 49 bits as Z + X + carryin when opmode[7]=0, and as Z - (X + carryin) when opmode[7]=1.
REQ-020 Bits[47:0] of the sum SHALL drive the P path, and bit 48 SHALL drive the carryout path.
REQ-021 With PREG=1, P SHALL update to the sum one cycle after its operands when cep=1, and SHALL hold its value when cep=0.
REQ-022 With PREG=0, p SHALL equal the sum combinationally with zero latency.
REQ-023 P feedback SHALL be the registered P; with PREG=0, any select of P feedback SHALL yield zero so that no combinational loop exists.
REQ-024 CARRYOUTREG SHALL apply to carryout with the same register/bypass and cep rules as PREG applies to P.
REQ-025 Accumulation (opmode X or Z select of P) SHALL wrap modulo 2^48 with no saturation.
REQ-026 When cep=1 and opmode changes on the same cycle, the register SHALL capture the sum formed under the new opmode.

Reset
REQ-027 When reset=1 at a clock edge, the P, carryout and ovf registers SHALL clear to 0 regardless of cep.
REQ-028 Reset SHALL take priority over cep; an accumulation in progress is discarded, and the next accumulation restarts from 0.
REQ-029 In bypass mode (PREG=0 or CARRYOUTREG=0), reset SHALL NOT affect the combinational outputs.

Configuration
REQ-030 With macro DSP_POSTADD_OVF_EN defined, ovf SHALL set when a captured 48-bit result signed-overflows (the operands share a sign and the result sign differs), then hold until reset.
REQ-031 The ovf register SHALL update only when cep=1, and SHALL exist only when PREG=1.
REQ-032 Without DSP_POSTADD_OVF_EN, ovf SHALL be tied to 0 and no overflow logic SHALL be synthesised.

Structure
REQ-033 The shared package dsp_pkg SHALL hold the X/Z select encodings, the OPMODE bit-index constants and the 48-bit P width constant.
REQ-034 A single sub-module reg_mux_nbit_sync (parameterised width, register/bypass select, sync reset, clken) SHALL implement both the P stage and the carryout stage.

Verification
REQ-035 Scenario 1: PREG=1, opmode=0x0F (Z=c, X=dab), c=100, dab=23, carryin=1, cep=1 -> p=124 and carryout=0 one cycle later.
REQ-036 Scenario 2: opmode=0x8F, c=100, dab=23, carryin=0 -> p=77; then c=0, dab=1 -> p=0xFFFFFFFFFFFF with carryout=1 (borrow).
REQ-037 Scenario 3: accumulate with opmode=0x09 (Z=P, X=m), m=5 for 4 cycles from reset -> p = 5, 10, 15, 20; cep=0 for 2 cycles -> p holds 20.
REQ-038 Scenario 4: p=0xFFFFFFFFFFFF, then opmode=0x0D (Z=c, X=m) with m=0, c=0xFFFFFFFFFFFF, carryin=1 -> p=0 and carryout=1 (wrap-around).
REQ-039 Scenario 5: reset=1 mid-accumulation with cep=0 -> p=0 and carryout=0 next edge; PREG=0 with opmode=0x0A -> p equals the combinational Z-zero/X-zero result.
REQ-040 Scenario 6 (DSP_POSTADD_OVF_EN defined): c=0x7FFFFFFFFFFF, dab=1, opmode=0x0F -> ovf=1 and stays 1 after the following non-overflowing sums until reset.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared constants and select encodings for the DSP post-adder slice.
package dsp_pkg;

   localparam int P_W = 48;
   localparam int M_W = 36;

   localparam int OP_SUB  = 7;
   localparam int OP_Z_HI = 3;
   localparam int OP_Z_LO = 2;
   localparam int OP_X_HI = 1;
   localparam int OP_X_LO = 0;

   typedef enum logic [1:0] {
      X_ZERO = 2'd0,
      X_M    = 2'd1,
      X_P    = 2'd2,
      X_DAB  = 2'd3
   } x_sel_e;

   typedef enum logic [1:0] {
      Z_ZERO = 2'd0,
      Z_PCIN = 2'd1,
      Z_P    = 2'd2,
      Z_C    = 2'd3
   } z_sel_e;

endpackage

// File: rtl/reg_mux_nbit_sync.sv
// Optional pipeline register: REG=1 registers d with sync reset and
// clock enable, REG=0 passes d straight through.
module reg_mux_nbit_sync #(
   parameter int W   = 48,
   parameter bit REG = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_r;

   always_ff @(posedge clk) begin
      if (reset)
         q_r <= '0;
      else if (ce)
         q_r <= d;
   end

   assign q = REG ? q_r : d;

endmodule

// File: rtl/dsp_post_adder.sv
// DSP post-adder: X/Z muxes, 49-bit add/sub, optional P/carryout regs.
// Sticky signed-overflow flag is built only with DSP_POSTADD_OVF_EN.
module dsp_post_adder
   import dsp_pkg::*;
#(
   parameter bit PREG        = 1'b1,
   parameter bit CARRYOUTREG = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           cep,
   input  logic [7:0]     opmode,
   input  logic [M_W-1:0] m,
   input  logic [P_W-1:0] dab,
   input  logic [P_W-1:0] pcin,
   input  logic [P_W-1:0] c,
   input  logic           carryin,
   output logic [P_W-1:0] p,
   output logic [P_W-1:0] pcout,
   output logic           carryout,
   output logic           carryoutf,
   output logic           ovf
);

   logic [P_W-1:0] x;
   logic [P_W-1:0] z;
   logic [P_W-1:0] p_fb;
   logic [P_W:0]   add_x;
   logic [P_W:0]   sum;
   logic           sub;
   logic           unused_op;
   x_sel_e         x_sel;
   z_sel_e         z_sel;

   assign unused_op = ^opmode[6:4];
   assign sub       = opmode[OP_SUB];
   assign x_sel     = x_sel_e'(opmode[OP_X_HI:OP_X_LO]);
   assign z_sel     = z_sel_e'(opmode[OP_Z_HI:OP_Z_LO]);

   // Without a P register there is nothing safe to feed back.
   assign p_fb = PREG ? p : '0;

   always_comb begin
      x = '0;
      unique case (x_sel)
         X_ZERO: x = '0;
         X_M:    x = {{(P_W-M_W){m[M_W-1]}}, m};
         X_P:    x = p_fb;
         X_DAB:  x = dab;
      endcase
   end

   always_comb begin
      z = '0;
      unique case (z_sel)
         Z_ZERO: z = '0;
         Z_PCIN: z = pcin;
         Z_P:    z = p_fb;
         Z_C:    z = c;
      endcase
   end

   assign add_x = {1'b0, x} + {{P_W{1'b0}}, carryin};
   assign sum   = sub ? ({1'b0, z} - add_x) : ({1'b0, z} + add_x);

   reg_mux_nbit_sync #(.W(P_W), .REG(PREG)) u_p_stage (
      .clk   (clk),
      .reset (reset),
      .ce    (cep),
      .d     (sum[P_W-1:0]),
      .q     (p)
   );

   reg_mux_nbit_sync #(.W(1), .REG(CARRYOUTREG)) u_co_stage (
      .clk   (clk),
      .reset (reset),
      .ce    (cep),
      .d     (sum[P_W]),
      .q     (carryout)
   );

   assign pcout     = p;
   assign carryoutf = carryout;

`ifdef DSP_POSTADD_OVF_EN
   logic ovf_now;

   // Subtraction overflows when the operand signs differ.
   assign ovf_now = (sum[P_W-1] != z[P_W-1]) &&
                    (sub ? (z[P_W-1] != x[P_W-1])
                         : (z[P_W-1] == x[P_W-1]));

   if (PREG) begin : g_ovf
      logic ovf_q;
      always_ff @(posedge clk) begin
         if (reset)
            ovf_q <= 1'b0;
         else if (cep && ovf_now)
            ovf_q <= 1'b1;
      end
      assign ovf = ovf_q;
   end else begin : g_no_ovf
      logic unused_ovf;
      assign unused_ovf = ovf_now;
      assign ovf        = 1'b0;
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_post_adder.sv
// Scoreboard bench for dsp_post_adder: registered and bypass instances.
module tb_dsp_post_adder;

   logic        clk = 1'b0;
   logic        reset;
   logic        cep;
   logic [7:0]  opmode;
   logic [35:0] m;
   logic [47:0] dab;
   logic [47:0] pcin;
   logic [47:0] c;
   logic        carryin;

   logic [47:0] p, pcout, p_b, pcout_b;
   logic        carryout, carryoutf, ovf;
   logic        carryout_b, carryoutf_b, ovf_b;

   typedef struct {
      logic [47:0] p;
      logic        co;
      logic        ov;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   logic [47:0] mp    = '0;
   logic        mco   = 1'b0;
   logic        movf  = 1'b0;

   localparam logic [47:0] ALL1 = 48'hFFFF_FFFF_FFFF;

   always #5 clk = ~clk;

   dsp_post_adder u_dut (
      .clk       (clk),
      .reset     (reset),
      .cep       (cep),
      .opmode    (opmode),
      .m         (m),
      .dab       (dab),
      .pcin      (pcin),
      .c         (c),
      .carryin   (carryin),
      .p         (p),
      .pcout     (pcout),
      .carryout  (carryout),
      .carryoutf (carryoutf),
      .ovf       (ovf)
   );

   dsp_post_adder #(.PREG(1'b0), .CARRYOUTREG(1'b0)) u_byp (
      .clk       (clk),
      .reset     (reset),
      .cep       (cep),
      .opmode    (opmode),
      .m         (m),
      .dab       (dab),
      .pcin      (pcin),
      .c         (c),
      .carryin   (carryin),
      .p         (p_b),
      .pcout     (pcout_b),
      .carryout  (carryout_b),
      .carryoutf (carryoutf_b),
      .ovf       (ovf_b)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // Reference sum in 64-bit arithmetic, truncated to 49 bits.
   function automatic logic [48:0] ref_sum(input logic [47:0] pfb,
                                           output logic ov);
      logic [63:0] xx, zz, s;
      case (opmode[1:0])
         2'd0: xx = 0;
         2'd1: xx = {{28{m[35]}}, m};
         2'd2: xx = {16'b0, pfb};
         default: xx = {16'b0, dab};
      endcase
      case (opmode[3:2])
         2'd0: zz = 0;
         2'd1: zz = {16'b0, pcin};
         2'd2: zz = {16'b0, pfb};
         default: zz = {16'b0, c};
      endcase
      xx = xx & 64'h0000_FFFF_FFFF_FFFF;
      if (opmode[7])
         s = zz - xx - 64'(carryin);
      else
         s = zz + xx + 64'(carryin);
      if (opmode[7])
         ov = (zz[47] != xx[47]) && (s[47] != zz[47]);
      else
         ov = (zz[47] == xx[47]) && (s[47] != zz[47]);
      return s[48:0];
   endfunction

   task automatic step(input logic rst, input logic ce,
                       input logic [7:0] op, input logic [35:0] mv,
                       input logic [47:0] dv, input logic [47:0] cv,
                       input logic [47:0] pv, input logic ci);
      logic [48:0] s;
      logic        ov;
      exp_t        e;
      exp_t        g;
      reset   = rst;
      cep     = ce;
      opmode  = op;
      m       = mv;
      dab     = dv;
      c       = cv;
      pcin    = pv;
      carryin = ci;
      #1;
      s = ref_sum('0, ov);
      chk("byp_p", {16'b0, p_b}, {16'b0, s[47:0]});
      chk("byp_co", {63'b0, carryout_b}, {63'b0, s[48]});
      chk("byp_ovf", {63'b0, ovf_b}, 64'd0);
      s = ref_sum(mp, ov);
      if (rst) begin
         mp = '0; mco = 1'b0; movf = 1'b0;
      end else if (ce) begin
         mp = s[47:0]; mco = s[48];
`ifdef DSP_POSTADD_OVF_EN
         movf = movf | ov;
`endif
      end
      e.p = mp; e.co = mco; e.ov = movf;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 64'd0, 64'd1);
      end else begin
         g = exp_q.pop_front();
         chk("p", {16'b0, p}, {16'b0, g.p});
         chk("co", {63'b0, carryout}, {63'b0, g.co});
         chk("ovf", {63'b0, ovf}, {63'b0, g.ov});
         chk("pcout", {16'b0, pcout}, {16'b0, g.p});
         chk("coutf", {63'b0, carryoutf}, {63'b0, g.co});
      end
   endtask

   initial begin
      step(1, 1, 8'h00, 0, 0, 0, 0, 0);
      step(1, 0, 8'h0F, 0, 5, 5, 0, 1);
      chk("rst_p", {16'b0, p}, 64'd0);

      step(0, 1, 8'h0F, 0, 48'd23, 48'd100, 0, 1);
      chk("s1_p", {16'b0, p}, 64'd124);
      chk("s1_co", {63'b0, carryout}, 64'd0);

      step(0, 1, 8'h8F, 0, 48'd23, 48'd100, 0, 0);
      chk("s2_p", {16'b0, p}, 64'd77);
      step(0, 1, 8'h8F, 0, 48'd1, 48'd0, 0, 0);
      chk("s2_borrow_p", {16'b0, p}, {16'b0, ALL1});
      chk("s2_borrow_co", {63'b0, carryout}, 64'd1);

      step(0, 1, 8'h0D, 0, 0, ALL1, 0, 1);
      chk("s4_wrap_p", {16'b0, p}, 64'd0);
      chk("s4_wrap_co", {63'b0, carryout}, 64'd1);

      step(1, 1, 8'h09, 36'd5, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         step(0, 1, 8'h09, 36'd5, 0, 0, 0, 0);
         chk("s3_acc", {16'b0, p}, 64'(5 * i));
      end
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 8'h09, 36'd5, 0, 0, 0, 0);
         chk("s3_hold", {16'b0, p}, 64'd20);
      end

      step(0, 1, 8'h09, 36'd5, 0, 0, 0, 0);
      step(1, 0, 8'h09, 36'd5, 0, 0, 0, 0);
      chk("s5_rst_p", {16'b0, p}, 64'd0);
      chk("s5_rst_co", {63'b0, carryout}, 64'd0);
      step(0, 1, 8'h0A, 0, 0, 0, 0, 0);
      step(0, 1, 8'h7F, 0, 48'd3, 48'd4, 0, 1);
      chk("ign_bits", {16'b0, p}, 64'd8);
      step(0, 1, 8'h0D, 36'hF_FFFF_FFFE, 0, 48'd10, 0, 0);
      chk("m_sext", {16'b0, p}, 64'd8);
      step(0, 1, 8'h0A, 0, 0, 0, 0, 1);
      chk("p_dbl", {16'b0, p}, 64'd17);

      step(1, 1, 8'h00, 0, 0, 0, 0, 0);
      step(0, 1, 8'h0F, 0, 48'd1, 48'h7FFF_FFFF_FFFF, 0, 0);
      step(0, 1, 8'h0F, 0, 48'd1, 48'd2, 0, 0);
      step(0, 1, 8'h04, 0, 0, 0, 48'd9, 0);
`ifdef DSP_POSTADD_OVF_EN
      chk("s6_sticky", {63'b0, ovf}, 64'd1);
`else
      chk("s6_tied0", {63'b0, ovf}, 64'd0);
`endif
      step(1, 0, 8'h04, 0, 0, 0, 48'd9, 0);
      chk("s6_clr", {63'b0, ovf}, 64'd0);

      for (int i = 0; i < 60; i++) begin
         step(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
              8'($urandom), 36'({$urandom, $urandom}),
              48'({$urandom, $urandom}), 48'({$urandom, $urandom}),
              48'({$urandom, $urandom}), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=0 want=1");
      $fatal(1, "timeout");
   end

endmodule
